// File: rtl/hermes_input_buffer_pkg.sv
// HermesPkg: shared router types. Holds the port enumeration used across the
// router and the input-buffer FSM states shared with the switch and benches.
package HermesPkg;

  localparam int NPORT = 5;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } hermes_port_t;

  // One-hot so the switch can test a single bit per state.
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    REQ     = 5'b00010,
    HEADER  = 5'b00100,
    SIZE    = 5'b01000,
    PAYLOAD = 5'b10000
  } hermes_ibuf_state_t;

  // Occupancy counter width: must be able to hold the value `depth` itself.
  function automatic int unsigned ibuf_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hermes_input_buffer_if.sv
// Port bundle of one Hermes input buffer: upstream link, routing handshake to
// the switch and the flit path toward the crossbar.
//
// Handshakes:
//   upstream : a flit moves when rx_i && credit_o at a rising clock edge;
//              credit_o is the "ready", rx_i the "valid".
//   crossbar : a flit moves when tx_o && credit_i at a rising clock edge;
//              tx_o is the "valid", credit_i the "ready". tx_o never depends
//              combinationally on credit_i.
//   routing  : req_o is held until the edge that samples ack_i = 1; ack_i is
//              a single-cycle pulse from the switch.
interface hermes_input_buffer_if #(
  parameter int FLIT_SIZE = 32
);

  logic                  rx_i;
  logic [FLIT_SIZE-1:0]  data_i;
  logic                  credit_o;
  logic                  req_o;
  logic                  ack_i;
  logic                  sending_o;
  logic                  tx_o;
  logic                  credit_i;
  logic [FLIT_SIZE-1:0]  data_o;

  // Observation-only signals: FSM state and payload flits still to send.
  HermesPkg::hermes_ibuf_state_t state_dbg;
  logic [FLIT_SIZE-1:0]          remaining_dbg;

  // master: the input buffer itself.
  modport master (
    input  rx_i, data_i, ack_i, credit_i,
    output credit_o, req_o, sending_o, tx_o, data_o, state_dbg, remaining_dbg
  );

  // slave: upstream link / switch / crossbar side.
  modport slave (
    output rx_i, data_i, ack_i, credit_i,
    input  credit_o, req_o, sending_o, tx_o, data_o, state_dbg, remaining_dbg
  );

endinterface

// File: rtl/hermes_fifo.sv
// Circular flit store for the Hermes input buffer. Occupancy is tracked by the
// owner, which supplies full/empty; this block only guards against pushing
// into a full buffer or popping an empty one.
module hermes_fifo #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 full,
  input  logic                 empty,
  input  logic [FLIT_SIZE-1:0] wr_data,
  output logic [FLIT_SIZE-1:0] head_data
);

  localparam int PW = $clog2(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;

  // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push && !full) begin
        mem[tail_q] <= wr_data;
        tail_q      <= tail_q + 1'b1;
      end
      if (pop && !empty) begin
        head_q <= head_q + 1'b1;
      end
    end
  end

  assign head_data = mem[head_q];

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes router input buffer: buffers upstream flits under credit flow control,
// requests routing when a header reaches the head, then streams header, size
// and payload flits to the crossbar while holding sending_o.
module hermes_input_buffer #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hermes_input_buffer_if.master bus
);
  import HermesPkg::*;

  localparam int unsigned CW = ibuf_count_width(BUFFER_SIZE);

  hermes_ibuf_state_t    state_q, state_d;
  logic [CW-1:0]         count_q;
  logic [FLIT_SIZE-1:0]  remaining_q, remaining_d;
  logic [FLIT_SIZE-1:0]  head_data;
  logic                  full, empty;
  logic                  push, pop;
  logic                  sending, tx, req;

  assign full    = (count_q == CW'(BUFFER_SIZE));
  assign empty   = (count_q == '0);
  assign sending = (state_q == HEADER) || (state_q == SIZE) || (state_q == PAYLOAD);
  assign tx      = sending && !empty;
  assign push    = bus.rx_i && !full;
  assign pop     = tx && bus.credit_i;

  hermes_fifo #(
    .FLIT_SIZE   (FLIT_SIZE),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .wr_data   (bus.data_i),
    .head_data (head_data)
  );

  // Occupancy: the single source of full/empty; a simultaneous push and pop
  // leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !push) begin
      count_q <= count_q - 1'b1;
    end
  end

  // FSM state and payload down-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state: request routing for a buffered header, then walk the packet;
  // states only advance on an actual crossbar transfer.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    req         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (bus.ack_i) state_d = HEADER;
      end
      HEADER: begin
        if (pop) state_d = SIZE;
      end
      SIZE: begin
        if (pop) begin
          remaining_d = head_data;
          state_d     = (head_data == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pop) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == FLIT_SIZE'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.credit_o      = !full;
  assign bus.req_o         = req;
  assign bus.sending_o     = sending;
  assign bus.tx_o          = tx;
  assign bus.data_o        = head_data;
  assign bus.state_dbg     = state_q;
  assign bus.remaining_dbg = remaining_q;

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed bench for hermes_input_buffer: reset, single packet, full buffer,
// zero-size packet, back-to-back wrap-around, backpressure, reset mid-packet.
module tb_hermes_input_buffer;
  import HermesPkg::*;

  localparam int FW = 32;
  localparam int BS = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];

  hermes_input_buffer_if #(.FLIT_SIZE(FW)) bus ();

  hermes_input_buffer #(
    .FLIT_SIZE   (FW),
    .BUFFER_SIZE (BS)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Crossbar-side capture of every transferred flit.
  always @(posedge clk) begin
    if (rst_n && bus.tx_o && bus.credit_i) got_q.push_back(bus.data_o);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_flit(input logic [FW-1:0] d);
    bus.rx_i   = 1'b1;
    bus.data_i = d;
    exp_q.push_back(d);
    step();
    bus.rx_i   = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [FW-1:0] e, g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  logic [FW-1:0] stream [14];
  int wi, rises, fall_cyc, rise2_cyc, xfers;
  logic prev_req, prev_send;

  initial begin
    rst_n      = 1'b0;
    bus.rx_i   = 1'b0;
    bus.data_i = '0;
    bus.ack_i  = 1'b0;
    bus.credit_i = 1'b1;

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_credit", bus.credit_o, 1);
    check("rst_req", bus.req_o, 0);
    check("rst_sending", bus.sending_o, 0);
    check("rst_tx", bus.tx_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // ---- single packet: header 0x102, size 3, three payloads ----
    write_flit(32'h0000_0102);
    check("sp_head_visible", bus.data_o, 32'h0000_0102);
    check("sp_req_not_yet", bus.req_o, 0);
    write_flit(32'd3);
    check("sp_req_rise", bus.req_o, 1);
    write_flit(32'hA1);
    write_flit(32'hA2);
    write_flit(32'hA3);
    check("sp_no_tx_before_ack", bus.tx_o, 0);
    step();
    pulse_ack();
    check("sp_state_header", 32'(bus.state_dbg), 32'(HEADER));
    check("sp_req_fall", bus.req_o, 0);
    check("sp_data_header", bus.data_o, 32'h0000_0102);
    for (int i = 0; i < 5; i++) begin
      check("sp_tx", bus.tx_o, 1);
      check("sp_sending", bus.sending_o, 1);
      step();
    end
    check("sp_sending_fall", bus.sending_o, 0);
    check("sp_tx_end", bus.tx_o, 0);
    check("sp_state_idle", 32'(bus.state_dbg), 32'(IDLE));
    check_sb("sp");

    // ---- full buffer ----
    bus.credit_i = 1'b0;
    write_flit(32'h0000_0200);
    write_flit(32'd6);
    for (int i = 1; i <= 6; i++) begin
      write_flit(32'h2F0 + 32'(i));
    end
    check("full_credit_low", bus.credit_o, 0);
    bus.rx_i   = 1'b1;
    bus.data_i = 32'hDEAD;
    step();
    bus.rx_i   = 1'b0;
    check("full_still_full", bus.credit_o, 0);
    check("full_state_req", 32'(bus.state_dbg), 32'(REQ));
    pulse_ack();
    check("full_tx", bus.tx_o, 1);
    check("full_no_xfer_head", bus.data_o, 32'h0000_0200);
    bus.credit_i = 1'b1;
    step();
    bus.credit_i = 1'b0;
    check("full_credit_back", bus.credit_o, 1);
    check("full_state_size", 32'(bus.state_dbg), 32'(SIZE));
    check("full_data_size", bus.data_o, 32'd6);
    bus.credit_i = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("full_state_idle", 32'(bus.state_dbg), 32'(IDLE));
    step();
    check("full_extra_dropped_req", bus.req_o, 0);
    check("full_extra_dropped_tx", bus.tx_o, 0);
    check_sb("full");

    // ---- zero-size packet ----
    write_flit(32'h0000_0300);
    write_flit(32'd0);
    check("zs_req", bus.req_o, 1);
    pulse_ack();
    check("zs_state_header", 32'(bus.state_dbg), 32'(HEADER));
    step();
    check("zs_state_size", 32'(bus.state_dbg), 32'(SIZE));
    check("zs_sending_mid", bus.sending_o, 1);
    step();
    check("zs_state_idle", 32'(bus.state_dbg), 32'(IDLE));
    check("zs_sending_fall", bus.sending_o, 0);
    check("zs_tx", bus.tx_o, 0);
    check_sb("zs");

    // ---- back-to-back packets of size 5, written while streaming ----
    stream[0] = 32'h0000_0401;
    stream[1] = 32'd5;
    stream[7] = 32'h0000_0402;
    stream[8] = 32'd5;
    for (int i = 0; i < 5; i++) begin
      stream[2 + i] = 32'hA0 + 32'(i);
      stream[9 + i] = 32'hB0 + 32'(i);
    end
    wi = 0; rises = 0; fall_cyc = -1; rise2_cyc = -1;
    prev_req = 1'b0; prev_send = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (wi < 14) begin
        bus.rx_i   = 1'b1;
        bus.data_i = stream[wi];
        exp_q.push_back(stream[wi]);
        wi++;
      end else begin
        bus.rx_i = 1'b0;
      end
      bus.ack_i = bus.req_o;
      step();
      if (bus.req_o && !prev_req) begin
        rises++;
        if (rises == 2) rise2_cyc = c;
      end
      if (!bus.sending_o && prev_send && fall_cyc < 0) fall_cyc = c;
      prev_req  = bus.req_o;
      prev_send = bus.sending_o;
      if (wi == 14 && got_q.size() == 14 && !bus.sending_o) break;
    end
    bus.rx_i  = 1'b0;
    bus.ack_i = 1'b0;
    check("b2b_req_rises", rises, 2);
    check("b2b_gap", rise2_cyc - fall_cyc, 1);
    check("b2b_state_idle", 32'(bus.state_dbg), 32'(IDLE));
    check_sb("b2b");

    // ---- backpressure in payload: credit_i toggles every cycle ----
    write_flit(32'h0000_0500);
    write_flit(32'd4);
    for (int i = 0; i < 4; i++) write_flit(32'hC0 + 32'(i));
    pulse_ack();
    for (int c = 0; c <= 10; c++) begin
      bus.credit_i = (c % 2 == 0);
      step();
      xfers = c / 2 + 1;
      if (xfers < 6) begin
        check("bp_sending", bus.sending_o, 1);
        if (xfers >= 2) begin
          check("bp_state_payload", 32'(bus.state_dbg), 32'(PAYLOAD));
          check("bp_remaining", bus.remaining_dbg, 32'(4 - (xfers - 2)));
        end
      end
    end
    bus.credit_i = 1'b1;
    check("bp_state_idle", 32'(bus.state_dbg), 32'(IDLE));
    check("bp_sending_fall", bus.sending_o, 0);
    check("bp_remaining_zero", bus.remaining_dbg, 0);
    check_sb("bp");

    // ---- reset mid-packet ----
    write_flit(32'h0000_0700);
    write_flit(32'd3);
    write_flit(32'hE0);
    pulse_ack();
    step();
    step();
    bus.credit_i = 1'b0;
    check("mr_state_payload", 32'(bus.state_dbg), 32'(PAYLOAD));
    check("mr_tx_pending", bus.tx_o, 1);
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    step();
    check("mr_credit", bus.credit_o, 1);
    check("mr_req", bus.req_o, 0);
    check("mr_sending", bus.sending_o, 0);
    check("mr_tx", bus.tx_o, 0);
    check("mr_data", bus.data_o, 0);
    check("mr_remaining", bus.remaining_dbg, 0);
    rst_n = 1'b1;
    bus.credit_i = 1'b1;
    step();
    step();
    check("mr_discarded_req", bus.req_o, 0);
    check("mr_discarded_tx", bus.tx_o, 0);
    check_sb("mr");

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
